// File: rtl/fall_edge_gen_pkg.sv
// Shared types and constants for the falling-edge waveform generator.
package fall_edge_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    FIN  = 2'd3
  } state_e;

  localparam logic WAVE_IDLE = 1'b1;

endpackage

// File: rtl/phase_counter.sv
// Down-counter timing one LOW or HIGH phase; reloaded at every phase start.
module phase_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturates at zero so an idle enable can never wrap the count.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (en_i && (cnt_q != '0))
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/fall_edge_gen.sv
// Emits a train of N low/high pulses (N falling edges) on a registered line.
module fall_edge_gen
  import fall_edge_gen_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter int NUM_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] low_len,
  input  logic [CNT_W-1:0] high_len,
  input  logic [NUM_W-1:0] num_pulses,
  output logic             wave_out,
  output logic             busy,
  output logic             done,
  output logic [NUM_W-1:0] edge_cnt
);

  state_e           state_q, state_d;
  logic             wave_q, wave_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [NUM_W-1:0] ecnt_q, ecnt_d;
  logic [NUM_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] llen_q, llen_d;
  logic [CNT_W-1:0] hlen_q, hlen_d;

  logic             ph_load, ph_en, ph_zero;
  logic [CNT_W-1:0] ph_val;
  logic [CNT_W-1:0] low_eff, high_eff;

  // A zero length would otherwise mean a 2^CNT_W cycle phase; clamp to 1.
  assign low_eff  = (low_len  == '0) ? CNT_W'(1) : low_len;
  assign high_eff = (high_len == '0) ? CNT_W'(1) : high_len;

  phase_counter #(.CNT_W(CNT_W)) u_phase (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (ph_load),
    .en_i       (ph_en),
    .load_val_i (ph_val),
    .zero_o     (ph_zero)
  );

  always_comb begin
    state_d = state_q;
    wave_d  = wave_q;
    busy_d  = busy_q;
    done_d  = done_q;
    ecnt_d  = ecnt_q;
    rem_d   = rem_q;
    llen_d  = llen_q;
    hlen_d  = hlen_q;
    ph_load = 1'b0;
    ph_en   = 1'b0;
    ph_val  = '0;

    unique case (state_q)
      IDLE: begin
        wave_d = WAVE_IDLE;
        busy_d = 1'b0;
        if (start && !abort) begin
          if (num_pulses != '0) begin
            llen_d  = low_eff;
            hlen_d  = high_eff;
            rem_d   = num_pulses;
            wave_d  = 1'b0;
            busy_d  = 1'b1;
            ecnt_d  = NUM_W'(1);
            state_d = LOW;
            ph_load = 1'b1;
            ph_val  = low_eff - 1'b1;
          end else begin
            // Empty train still reports completion through FIN.
            done_d  = 1'b1;
            ecnt_d  = '0;
            state_d = FIN;
          end
        end
      end

      LOW: begin
        if (abort) begin
          wave_d  = WAVE_IDLE;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          ph_en = 1'b1;
          if (ph_zero) begin
            wave_d  = 1'b1;
            state_d = HIGH;
            ph_load = 1'b1;
            ph_val  = hlen_q - 1'b1;
          end
        end
      end

      HIGH: begin
        if (abort) begin
          wave_d  = WAVE_IDLE;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          ph_en = 1'b1;
          if (ph_zero) begin
            if (rem_q > NUM_W'(1)) begin
              wave_d  = 1'b0;
              ecnt_d  = ecnt_q + 1'b1;
              rem_d   = rem_q - 1'b1;
              state_d = LOW;
              ph_load = 1'b1;
              ph_val  = llen_q - 1'b1;
            end else begin
              busy_d  = 1'b0;
              done_d  = 1'b1;
              state_d = FIN;
            end
          end
        end
      end

      FIN: begin
        done_d  = 1'b0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wave_q  <= WAVE_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ecnt_q  <= '0;
      rem_q   <= '0;
      llen_q  <= '0;
      hlen_q  <= '0;
    end else begin
      state_q <= state_d;
      wave_q  <= wave_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ecnt_q  <= ecnt_d;
      rem_q   <= rem_d;
      llen_q  <= llen_d;
      hlen_q  <= hlen_d;
    end
  end

  assign wave_out = wave_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign edge_cnt = ecnt_q;

endmodule

// File: tb/tb_fall_edge_gen.sv
// Self-checking bench: train table, corner sequences, random run against a position-based model.
module tb_fall_edge_gen;

  localparam int CNT_W = 8;
  localparam int NUM_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [CNT_W-1:0] low_len = '0;
  logic [CNT_W-1:0] high_len = '0;
  logic [NUM_W-1:0] num_pulses = '0;
  logic             wave_out, busy, done;
  logic [NUM_W-1:0] edge_cnt;

  always #5 clk = ~clk;

  fall_edge_gen #(.CNT_W(CNT_W), .NUM_W(NUM_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .low_len    (low_len),
    .high_len   (high_len),
    .num_pulses (num_pulses),
    .wave_out   (wave_out),
    .busy       (busy),
    .done       (done),
    .edge_cnt   (edge_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model: a train is a position t in [0, N*(L+H)); wave is low for the first L of each period.
  bit m_act = 0, m_fin = 0, m_wave = 1, m_done = 0;
  int m_t = 0, m_L = 1, m_H = 1, m_N = 0, m_ecnt = 0;

  // Observed statistics, accumulated at each sample point.
  int busy_cnt = 0, fall_cnt = 0, done_cnt = 0, idle_cnt = 0;
  bit prev_wave = 1;

  typedef struct {
    int l, h, n;
    int exp_busy, exp_edges;
  } vec_t;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_act = 0; m_fin = 0; m_wave = 1; m_done = 0; m_ecnt = 0; m_t = 0;
  endtask

  task automatic model_step();
    if (m_act) begin
      if (abort) begin
        m_act = 0; m_wave = 1;
      end else begin
        m_t++;
        if (m_t == m_N * (m_L + m_H)) begin
          m_act = 0; m_fin = 1; m_done = 1; m_wave = 1;
        end else begin
          m_wave = (m_t % (m_L + m_H)) >= m_L;
          m_ecnt = m_t / (m_L + m_H) + 1;
        end
      end
    end else if (m_fin) begin
      m_fin = 0; m_done = 0;
    end else if (start && !abort) begin
      m_L = (low_len == 0) ? 1 : int'(low_len);
      m_H = (high_len == 0) ? 1 : int'(high_len);
      m_N = int'(num_pulses);
      if (m_N == 0) begin
        m_fin = 1; m_done = 1; m_ecnt = 0;
      end else begin
        m_act = 1; m_t = 0; m_wave = 0; m_ecnt = 1;
      end
    end
  endtask

  task automatic clear_stats();
    busy_cnt = 0; fall_cnt = 0; done_cnt = 0; idle_cnt = 0;
  endtask

  // One clock: step the model on the rising edge, compare on the falling edge.
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("outputs", {wave_out, busy, done, edge_cnt},
          {m_wave, m_act, m_done, NUM_W'(m_ecnt)});
    if (busy) busy_cnt++;
    if (!busy && !done) idle_cnt++;
    if (done) done_cnt++;
    if (prev_wave && !wave_out) fall_cnt++;
    prev_wave = wave_out;
  endtask

  task automatic set_train(input int l, input int h, input int n);
    low_len    = CNT_W'(l);
    high_len   = CNT_W'(h);
    num_pulses = NUM_W'(n);
  endtask

  task automatic run_train(input vec_t v);
    int guard;
    clear_stats();
    set_train(v.l, v.h, v.n);
    start = 1'b1;
    cycle();
    start = 1'b0;
    guard = 0;
    while (done_cnt == 0 && guard < 5000) begin
      cycle();
      guard++;
    end
    if (guard >= 5000) check("train_timeout", 1, 0);
    cycle();
    cycle();
    check("busy_cycles", busy_cnt, v.exp_busy);
    check("falling_edges", fall_cnt, v.exp_edges);
    check("edge_cnt", edge_cnt, v.exp_edges);
    check("done_pulses", done_cnt, 1);
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{2, 3, 4, 20, 4};
    vecs[1] = '{0, 0, 3, 6, 3};
    vecs[2] = '{4, 0, 0, 0, 0};
    vecs[3] = '{1, 1, 1, 2, 1};
    vecs[4] = '{255, 1, 2, 512, 2};
    vecs[5] = '{7, 2, 1, 9, 1};
    vecs[6] = '{1, 3, 255, 1020, 255};

    // Reset state
    #12;
    check("reset_state", {wave_out, busy, done, edge_cnt}, {1'b1, 1'b0, 1'b0, NUM_W'(0)});
    @(negedge clk);
    rst_n = 1'b1;
    cycle();

    foreach (vecs[i]) run_train(vecs[i]);

    // Asynchronous reset in the middle of a train
    set_train(3, 2, 5);
    start = 1'b1;
    cycle();
    start = 1'b0;
    for (int i = 0; i < 6; i++) cycle();
    #2 rst_n = 1'b0;
    #1;
    check("async_reset", {wave_out, busy, done, edge_cnt}, {1'b1, 1'b0, 1'b0, NUM_W'(0)});
    model_reset();
    prev_wave = 1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_train('{1, 2, 2, 6, 2});

    // Abort in the second pulse's HIGH phase
    clear_stats();
    set_train(4, 4, 10);
    start = 1'b1;
    cycle();
    start = 1'b0;
    for (int i = 0; i < 12; i++) cycle();
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    check("abort_state", {wave_out, busy, done, edge_cnt}, {1'b1, 1'b0, 1'b0, NUM_W'(2)});
    for (int i = 0; i < 4; i++) cycle();
    check("abort_no_done", done_cnt, 0);

    // Abort and start together in IDLE
    clear_stats();
    set_train(2, 2, 3);
    start = 1'b1;
    abort = 1'b1;
    cycle();
    start = 1'b0;
    abort = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    check("abort_start_busy", busy_cnt, 0);
    check("abort_start_edges", fall_cnt, 0);

    // Start held high: mid-train and FIN starts ignored, restart after one idle cycle
    clear_stats();
    set_train(1, 1, 2);
    start = 1'b1;
    for (int i = 0; i < 17; i++) cycle();
    start = 1'b0;
    check("b2b_done", done_cnt, 3);
    check("b2b_busy", busy_cnt, 12);
    check("b2b_idle_gap", idle_cnt, 2);
    check("b2b_edges", fall_cnt, 6);
    for (int i = 0; i < 3; i++) cycle();

    // Random traffic: starts, aborts and input changes at any time
    for (int i = 0; i < 1500; i++) begin
      start      = ($urandom_range(0, 3) == 0);
      abort      = ($urandom_range(0, 29) == 0);
      low_len    = CNT_W'($urandom_range(0, 5));
      high_len   = CNT_W'($urandom_range(0, 5));
      num_pulses = NUM_W'($urandom_range(0, 6));
      cycle();
    end
    start = 1'b0;
    abort = 1'b0;
    for (int i = 0; i < 5; i++) cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
